// File: rtl/neuron_sched_pkg.sv
// neuron_sched_pkg: shared types and constants for the neuron scheduler.
//   state_e    : scheduler FSM states
//   DEF_*      : default geometry and firing threshold
//   sum_width(): bits needed to hold a full weighted sum without overflow
package neuron_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

   localparam int unsigned DEF_NUM_SPIKES  = 16;
   localparam int unsigned DEF_WBITS       = 4;
   localparam int unsigned DEF_NUM_NEURONS = 8;
   localparam int unsigned DEF_THRESHOLD   = 32;

   // Worst case is every spike set with every weight at its maximum value.
   function automatic int unsigned sum_width(input int unsigned num_spikes,
                                             input int unsigned wbits);
      return $clog2(num_spikes * ((32'd1 << wbits) - 32'd1) + 32'd1);
   endfunction

endpackage

// File: rtl/neuron_acc.sv
// neuron_acc: combinational weighted sum of one weight row and threshold compare.
// Ports:
//   spikes  : latched input spike vector, one bit per synapse
//   weights : weight row, weight j at bits [j*WBITS +: WBITS]
//   fire    : 1 when the sum of weights with a set spike bit is >= THRESHOLD
module neuron_acc
   import neuron_sched_pkg::*;
#(
   parameter int unsigned NUM_SPIKES = DEF_NUM_SPIKES,
   parameter int unsigned WBITS      = DEF_WBITS,
   parameter int unsigned THRESHOLD  = DEF_THRESHOLD
) (
   input  logic [NUM_SPIKES-1:0]       spikes,
   input  logic [NUM_SPIKES*WBITS-1:0] weights,
   output logic                        fire
);

   localparam int unsigned SW = sum_width(NUM_SPIKES, WBITS);

   logic [SW-1:0] sum;

   always_comb begin
      sum = '0;
      for (int j = 0; j < NUM_SPIKES; j++) begin
         if (spikes[j]) begin
            sum = sum + SW'(weights[j*WBITS +: WBITS]);
         end
      end
   end

   // Compare at 32 bits so a threshold beyond the sum range simply never fires.
   assign fire = (32'(sum) >= 32'(THRESHOLD));

endmodule

// File: rtl/neuron_sched.sv
// neuron_sched: time-multiplexes NUM_NEURONS threshold neurons onto one neuron_acc.
// One weight row is read per RUN cycle; the row returns a cycle later and is
// evaluated against the spike vector latched at accept.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid, in_ready, in_spikes : input spike-vector handshake
//   wt_rd_en, wt_addr, wt_rd_data : weight-row memory, 1-cycle read latency
//   out_valid, out_ready, out_spikes : result handshake
//   busy                          : high whenever not idle
// Build option: define NEURON_SCHED_WTA_EN for winner-take-all output
// (only the lowest-index firing neuron is reported).
module neuron_sched
   import neuron_sched_pkg::*;
#(
   parameter int unsigned NUM_SPIKES  = DEF_NUM_SPIKES,
   parameter int unsigned WBITS       = DEF_WBITS,
   parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int unsigned THRESHOLD   = DEF_THRESHOLD,
   localparam int unsigned AW         = $clog2(NUM_NEURONS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_SPIKES-1:0]       in_spikes,
   output logic                        wt_rd_en,
   output logic [AW-1:0]               wt_addr,
   input  logic [NUM_SPIKES*WBITS-1:0] wt_rd_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_NEURONS-1:0]      out_spikes,
   output logic                        busy
);

   localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

   state_e                  state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic [NUM_SPIKES-1:0]   spikes_q, spikes_d;
   logic [NUM_NEURONS-1:0]  result_q, result_d;
   // eval_q marks that wt_rd_data holds the row read last cycle at eval_addr_q.
   logic                    eval_q, eval_d;
   logic [AW-1:0]           eval_addr_q, eval_addr_d;
   logic                    fire;

   neuron_acc #(
      .NUM_SPIKES (NUM_SPIKES),
      .WBITS      (WBITS),
      .THRESHOLD  (THRESHOLD)
   ) u_acc (
      .spikes  (spikes_q),
      .weights (wt_rd_data),
      .fire    (fire)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      spikes_d    = spikes_q;
      result_d    = result_q;
      eval_d      = 1'b0;
      eval_addr_d = eval_addr_q;
      in_ready    = 1'b0;
      wt_rd_en    = 1'b0;
      wt_addr     = '0;
      out_valid   = 1'b0;

      if (eval_q) begin
`ifdef NEURON_SCHED_WTA_EN
         // Rows arrive in ascending order, so the first fire seen is the winner.
         if (fire && (result_q == '0)) begin
            result_d[eval_addr_q] = 1'b1;
         end
`else
         result_d[eval_addr_q] = fire;
`endif
      end

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               spikes_d = in_spikes;
               result_d = '0;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            wt_rd_en    = 1'b1;
            wt_addr     = cnt_q;
            eval_d      = 1'b1;
            eval_addr_d = cnt_q;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         StDrain: begin
            state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         spikes_q    <= '0;
         result_q    <= '0;
         eval_q      <= 1'b0;
         eval_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         spikes_q    <= spikes_d;
         result_q    <= result_d;
         eval_q      <= eval_d;
         eval_addr_q <= eval_addr_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign out_spikes = result_q;

endmodule

// File: tb/tb_neuron_sched.sv
// tb_neuron_sched: directed self-checking bench for neuron_sched (default geometry).
// A behavioural weight memory returns rows[wt_addr] one cycle after wt_rd_en.
module tb_neuron_sched;

   localparam int NS = 16;
   localparam int WB = 4;
   localparam int NN = 8;
   localparam int TH = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_spikes = '0;
   logic          wt_rd_en;
   logic [2:0]    wt_addr;
   logic [63:0]   wt_rd_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [7:0]    out_spikes;
   logic          busy;

   logic [63:0]   rows [NN];
   int            n_checks = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   neuron_sched #(
      .NUM_SPIKES  (NS),
      .WBITS       (WB),
      .NUM_NEURONS (NN),
      .THRESHOLD   (TH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_spikes  (in_spikes),
      .wt_rd_en   (wt_rd_en),
      .wt_addr    (wt_addr),
      .wt_rd_data (wt_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_spikes (out_spikes),
      .busy       (busy)
   );

   always @(posedge clk) begin
      if (wt_rd_en) wt_rd_data <= rows[wt_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] expect_out(input logic [7:0] raw);
`ifdef NEURON_SCHED_WTA_EN
      return raw & (~raw + 8'd1);
`else
      return raw;
`endif
   endfunction

   task automatic fill_const(input logic [3:0] w);
      for (int k = 0; k < NN; k++)
         for (int j = 0; j < NS; j++) rows[k][j*WB +: WB] = w;
   endtask

   task automatic fill_index();
      for (int k = 0; k < NN; k++)
         for (int j = 0; j < NS; j++) rows[k][j*WB +: WB] = 4'(k);
   endtask

   // Presents one vector while idle; returns at the negedge after the accept edge.
   task automatic start_job(input logic [15:0] sp);
      @(negedge clk);
      in_valid  = 1'b1;
      in_spikes = sp;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   // Entered right after the accept edge; counts edges to out_valid and checks
   // the read address stream. With poke set, in_valid/in_spikes are wiggled mid-job.
   task automatic wait_done(input logic [7:0] raw, input string tag, input bit poke);
      int edges = 0;
      int n_rd = 0;
      bit seq_ok = 1'b1;
      while (!out_valid && edges < 50) begin
         if (wt_rd_en) begin
            if (wt_addr != 3'(n_rd)) seq_ok = 1'b0;
            n_rd++;
         end else if (wt_addr != 3'd0) begin
            seq_ok = 1'b0;
         end
         if (poke) begin
            in_valid  = edges[0];
            in_spikes = ~in_spikes;
         end
         @(negedge clk);
         edges++;
      end
      in_valid = 1'b0;
      check({tag, "/latency"}, edges, NN + 1);
      check({tag, "/reads"}, n_rd, NN);
      check({tag, "/addr_seq"}, {31'd0, seq_ok}, 1);
      check({tag, "/out_spikes"}, {24'd0, out_spikes}, {24'd0, expect_out(raw)});
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release/idle", {29'd0, busy, out_valid, in_ready}, 32'b001);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int cnt;
      fill_const(4'd4);
      #2;
      check("reset/ctl", {28'd0, busy, out_valid, wt_rd_en, in_ready}, 32'b0001);
      check("reset/out_spikes", {24'd0, out_spikes}, 0);
      check("reset/wt_addr", {29'd0, wt_addr}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sum exactly at threshold: 8 spikes * 4 = 32 for every neuron.
      start_job(16'h00FF);
      wait_done(8'hFF, "all4", 1'b0);
      release_out();

      // One below threshold: 7 * 4 = 28, nobody fires.
      start_job(16'h007F);
      wait_done(8'h00, "below", 1'b0);
      release_out();

      // Row k weights = k, all spikes: sums 16k, fire for k >= 2.
      fill_index();
      start_job(16'hFFFF);
      wait_done(8'hFC, "rowk", 1'b1);

      // Hold in DONE with out_ready low while in_valid toggles.
      for (int i = 0; i < 20; i++) begin
         in_valid  = i[0];
         in_spikes = 16'($urandom);
         @(negedge clk);
         check("hold", {21'd0, out_valid, in_ready, busy, out_spikes},
               {21'd0, 3'b101, expect_out(8'hFC)});
      end
      in_valid = 1'b0;
      release_out();

      // Half the spikes: sums 8k, fire for k >= 4.
      start_job(16'h00FF);
      wait_done(8'hF0, "rowk_half", 1'b0);

      // Back-to-back: out handshake, then accept exactly one cycle later.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_spikes = 16'hFFFF;
      @(negedge clk);
      check("b2b/idle", {29'd0, in_ready, out_valid, busy}, 32'b100);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("b2b/accept", {27'd0, busy, wt_rd_en, wt_addr}, {27'd0, 2'b11, 3'd0});
      wait_done(8'hFC, "b2b", 1'b0);
      release_out();

      // Reset in the middle of RUN at address 3.
      fill_const(4'd15);
      start_job(16'hFFFF);
      cnt = 0;
      while (wt_addr != 3'd3 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("rst_mid/reached_addr3", {29'd0, wt_addr}, 3);
      rst_n = 1'b0;
      #1;
      check("rst_mid/ctl", {28'd0, busy, out_valid, wt_rd_en, in_ready}, 32'b0001);
      check("rst_mid/out", {21'd0, wt_addr, out_spikes}, 0);
      fill_const(4'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid/no_valid", {31'd0, out_valid}, 0);
      end
      rst_n = 1'b1;

      // Fresh job after reset must not carry any partial bits.
      start_job(16'h007F);
      wait_done(8'h00, "post_rst", 1'b0);
      release_out();

      // Maximum weights, all spikes: sum 240 must not wrap.
      fill_const(4'd15);
      start_job(16'hFFFF);
      wait_done(8'hFF, "sat240", 1'b0);
      release_out();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/neuron_sched.md
NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 SHALL have parameter NUM_SPIKES, default 16: input spike vector width (synapses per neuron).
REQ-002 SHALL have parameter WBITS, default 4: unsigned weight width.
REQ-003 SHALL have parameter NUM_NEURONS, default 8: output neurons time-multiplexed onto one datapath, minimum 2.
REQ-004 SHALL have parameter THRESHOLD, default 32: firing threshold, unsigned.
REQ-005 SHALL have ports `clk` (input, 1): the single clock; `rst_n` (input, 1): asynchronous, active-low reset.
REQ-006 SHALL have ports `in_valid` (input, 1), `in_ready` (output, 1), `in_spikes` (input, NUM_SPIKES): input spike-vector handshake.
REQ-007 SHALL have ports `wt_rd_en` (output, 1), `wt_addr` (output, clog2(NUM_NEURONS)), `wt_rd_data` (input, NUM_SPIKES*WBITS): weight-row memory with 1-cycle read latency; weight j occupies bits [j*WBITS +: WBITS].
REQ-008 SHALL have ports `out_valid` (output, 1), `out_ready` (input, 1), `out_spikes` (output, NUM_NEURONS): result handshake.
REQ-009 SHALL have port `busy` (output, 1): high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-011 IDLE: in_ready=1; on in_valid&&in_ready, SHALL latch in_spikes, clear the result register, set the neuron counter to 0, and go to RUN.
REQ-012 RUN: wt_rd_en=1, wt_addr=counter; counter increments each cycle; after the cycle with addr NUM_NEURONS-1, SHALL go to DRAIN.
REQ-013 SHALL evaluate in every cycle after a read (RUN cycles 2..N and DRAIN): sum of weights whose latched spike bit is 1; result bit [addr of the previous cycle] = (sum >= THRESHOLD).
REQ-014 Sum width SHALL be clog2(NUM_SPIKES*(2^WBITS-1)+1) bits, unsigned, and SHALL never overflow.
REQ-015 DRAIN: wt_rd_en=0; SHALL store the last bit and go to DONE.
REQ-016 Latency: handshake accepted at edge 0 means out_valid=1 after edge NUM_NEURONS+1.
REQ-017 DONE: out_valid=1, out_spikes stable; on out_ready, SHALL go to IDLE; it SHALL hold indefinitely while out_ready=0.
REQ-018 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored and SHALL NOT corrupt the latched spikes.
REQ-019 wt_rd_en SHALL be 0 in IDLE, DRAIN and DONE; wt_addr SHALL be 0 when wt_rd_en=0.
REQ-020 No accept in the same cycle as the out handshake; the next input SHALL be accepted no earlier than the following cycle (IDLE).

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, counter=0, latched spikes=0, out_spikes=0, out_valid=0, wt_rd_en=0, busy=0, in_ready=1 (after release).
REQ-022 Reset mid-RUN/DRAIN/DONE SHALL discard the partial result with no out_valid pulse.

Configuration
REQ-023 SHALL support macro NEURON_SCHED_WTA_EN.
REQ-024 With NEURON_SCHED_WTA_EN defined, out_spikes SHALL be one-hot of the lowest-index firing neuron, or all-zero if none fired; result bits after the first winner SHALL be suppressed.
REQ-025 Without NEURON_SCHED_WTA_EN, out_spikes SHALL report every firing neuron independently.

Structure
REQ-026 A shared package SHALL hold the state enum, the default NUM_SPIKES, WBITS and THRESHOLD constants, and the sum-width function.
REQ-027 The weighted-sum/threshold compare SHALL be one combinational sub-module, neuron_acc (spikes, weight row -> fire); the FSM, counter and result register SHALL be in neuron_sched.

Verification
REQ-028 All weights 4, in_spikes=16'h00FF, THRESHOLD 32 -> sum 32 for every neuron; out_spikes=8'hFF at edge 9.
REQ-029 Row k weights = k (k=0..7), in_spikes all ones -> sums 0,16,...,112; out_spikes=8'hFC (8'h04 with NEURON_SCHED_WTA_EN).
REQ-030 out_ready held 0 for 20 cycles in DONE -> out_valid and out_spikes stable; in_ready=0; a toggling in_valid is ignored.
REQ-031 Back-to-back inputs with out_ready=1 -> second accept exactly one cycle after the out handshake; wt_addr sequence 0..7 per job.
REQ-032 rst_n asserted at RUN addr 3 -> same-cycle outputs at reset values; next job after release produces a correct, uncontaminated result.
REQ-033 All weights 15, in_spikes all ones -> sum 240 with no wrap; all neurons fire.
